// File: rtl/disp_pkg.sv
// Shared definitions for the display arbiter slice.
// Holds the arbiter state enum, the display word width, the
// maximum requester count and the select-width helper.
package disp_pkg;

  localparam int unsigned DISP_W       = 32;
  localparam int unsigned DISP_MAX_REQ = 8;

  typedef enum logic {
    DA_IDLE = 1'b0,
    DA_SHOW = 1'b1
  } da_state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned src_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/disp_rr_pick.sv
// Wrapped round-robin search for the display arbiter.
// Ports:
//   req   : candidate request vector
//   last  : index the search starts after; it is visited last
//   found : some bit of req is set
//   idx   : first set bit at or after (last+1) mod N_REQ, with wrap
module disp_rr_pick
  import disp_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned SW    = src_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SW-1:0]    last,
  output logic             found,
  output logic [SW-1:0]    idx
);

  logic [SW-1:0] pos;

  // Visit last+1 .. last+N_REQ (mod N_REQ); the first hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      pos = SW'((32'(last) + k) % N_REQ);
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/disp_arbiter.sv
// Round-robin time-sharing of the 8-digit display between N_REQ requesters,
// with a minimum dwell per grant, forwarding the owner's word to the scanner.
// Optional macro DISP_ARBITER_PRIO_EN gives requester 0 absolute priority.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   req          : level-sensitive request per requester
//   data_in      : requester i's word at [32*i+31:32*i]
//   gnt          : one-hot grant, zero when idle
//   disp_data    : registered word to the display scanner
//   disp_src     : index of the current or most recent owner
//   switch_pulse : one-cycle pulse on each new grant or ownership change
//   busy         : any grant active
module disp_arbiter
  import disp_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  parameter  int unsigned DWELL = 50_000_000,
  localparam int unsigned SW    = src_width(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [DISP_W*N_REQ-1:0] data_in,
  output logic [N_REQ-1:0]        gnt,
  output logic [DISP_W-1:0]       disp_data,
  output logic [SW-1:0]           disp_src,
  output logic                    switch_pulse,
  output logic                    busy
);

  localparam int unsigned     CW      = $clog2(DWELL);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DWELL - 1);

  if (N_REQ < 2 || N_REQ > DISP_MAX_REQ) begin : g_bad_n_req
    $error("disp_arbiter: N_REQ must be 2..%0d", DISP_MAX_REQ);
  end
  if (DWELL < 2) begin : g_bad_dwell
    $error("disp_arbiter: DWELL must be at least 2");
  end

  da_state_e           state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [SW-1:0]       last, last_n;
  logic [N_REQ-1:0]    gnt_n;
  logic [DISP_W-1:0]   data_n;
  logic [SW-1:0]       src_n;
  logic                pulse_n;
  logic                busy_n;

  logic [DISP_W-1:0]   words [N_REQ];
  logic [N_REQ-1:0]    others;
  logic                pick_found;
  logic [SW-1:0]       pick_idx;
  logic                owner_req;
  logic                prio_take;
  logic                hold_zero;
  logic                take;
  logic [SW-1:0]       take_idx;

  // Unpack the flat data bus into per-requester words.
  for (genvar i = 0; i < N_REQ; i++) begin : g_words
    assign words[i] = data_in[DISP_W*i +: DISP_W];
  end

  // Candidates exclude the current owner, so "found" means someone else waits.
  assign others    = req & ~gnt;
  assign owner_req = |(req & gnt);

`ifdef DISP_ARBITER_PRIO_EN
  // Requester 0 preempts any other owner and is never rotated away.
  assign prio_take = req[0] && !gnt[0];
  assign hold_zero = req[0] && gnt[0];
`else
  assign prio_take = 1'b0;
  assign hold_zero = 1'b0;
`endif

  disp_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req   (others),
    .last  (last),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    last_n   = last;
    gnt_n    = gnt;
    data_n   = disp_data;
    src_n    = disp_src;
    pulse_n  = 1'b0;
    take     = 1'b0;
    take_idx = pick_idx;

    unique case (state)
      DA_IDLE: begin
        if (prio_take) begin
          take     = 1'b1;
          take_idx = '0;
        end else if (pick_found) begin
          take = 1'b1;
        end
      end
      DA_SHOW: begin
        if (prio_take) begin
          take     = 1'b1;
          take_idx = '0;
        end else if (!owner_req) begin
          // Release wins over a coincident dwell expiry.
          if (pick_found) begin
            take = 1'b1;
          end else begin
            state_n = DA_IDLE;
            gnt_n   = '0;
          end
        end else if (cnt == CNT_MAX) begin
          data_n = words[last];
          if (pick_found && !hold_zero) begin
            take = 1'b1;
          end
        end else begin
          data_n = words[last];
          cnt_n  = cnt + CW'(1);
        end
      end
      default: begin
        state_n = DA_IDLE;
        gnt_n   = '0;
      end
    endcase

    if (take) begin
      state_n = DA_SHOW;
      gnt_n   = N_REQ'(1) << take_idx;
      last_n  = take_idx;
      src_n   = take_idx;
      data_n  = words[take_idx];
      cnt_n   = '0;
      pulse_n = 1'b1;
    end

    busy_n = |gnt_n;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= DA_IDLE;
      cnt          <= '0;
      last         <= SW'(N_REQ - 1);
      gnt          <= '0;
      disp_data    <= '0;
      disp_src     <= '0;
      switch_pulse <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      last         <= last_n;
      gnt          <= gnt_n;
      disp_data    <= data_n;
      disp_src     <= src_n;
      switch_pulse <= pulse_n;
      busy         <= busy_n;
    end
  end

endmodule

// File: tb/tb_disp_arbiter.sv
// Scoreboard bench for disp_arbiter (N_REQ=4, DWELL=8).
// Stimulus pushes the expected owner of each switch; the monitor pops
// on every switch_pulse and checks gnt, disp_src, disp_data and spacing.
module tb_disp_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req;
  logic [127:0] data_in;
  logic [3:0]   gnt;
  logic [31:0]  disp_data;
  logic [1:0]   disp_src;
  logic         switch_pulse;
  logic         busy;

  typedef struct {
    logic [3:0]  gnt;
    logic [1:0]  src;
    logic [31:0] data;
    int          gap;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_total = 0;
  int   n_pass  = 0;
  int   cyc     = 0;
  int   last_sw = 0;

  disp_arbiter #(
    .N_REQ (4),
    .DWELL (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .data_in      (data_in),
    .gnt          (gnt),
    .disp_data    (disp_data),
    .disp_src     (disp_src),
    .switch_pulse (switch_pulse),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expect a switch to requester idx; gap = cycles since previous switch (0: any).
  task automatic push(input int idx, input int gap);
    exp_t x;
    x.gnt  = 4'(1) << idx;
    x.src  = 2'(idx);
    x.data = 32'hA0A0_0000 + 32'(idx);
    x.gap  = gap;
    sb.push_back(x);
  endtask

  // Monitor: every switch pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && switch_pulse) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_switch: got gnt %b src %0d, expected no switch", gnt, disp_src);
      end else begin
        mon_e = sb.pop_front();
        check("sw_gnt",  32'(gnt),       32'(mon_e.gnt));
        check("sw_src",  32'(disp_src),  32'(mon_e.src));
        check("sw_data", disp_data,      mon_e.data);
        if (mon_e.gap > 0) check("sw_gap", 32'(cyc - last_sw), 32'(mon_e.gap));
      end
      last_sw = cyc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    for (int i = 0; i < 4; i++) data_in[32*i +: 32] = 32'hA0A0_0000 + 32'(i);

    // 1: reset values, then a single request
    tick(3);
    check("rst_gnt",   32'(gnt),          32'd0);
    check("rst_data",  disp_data,         32'd0);
    check("rst_src",   32'(disp_src),     32'd0);
    check("rst_pulse", 32'(switch_pulse), 32'd0);
    check("rst_busy",  32'(busy),         32'd0);
    rst_n = 1'b1;
    tick(1);
    req = 4'b0010;
    push(1, 0);
    tick(1);
    check("t1_gnt",  32'(gnt),  32'b0010);
    check("t1_busy", 32'(busy), 32'd1);
    tick(1);
    check("t1_pulse_once", 32'(switch_pulse), 32'd0);
    check("t1_data",       disp_data,         32'hA0A0_0001);
    req = 4'b0000;
    tick(1);
    check("t1_idle_gnt", 32'(gnt), 32'd0);

    // 2: all requesting, rotation 0,1,2,3,0 at DWELL cycles each
    do_reset();
    req = 4'b1111;
`ifdef DISP_ARBITER_PRIO_EN
    push(0, 0);
`else
    push(0, 0); push(1, 8); push(2, 8); push(3, 8); push(0, 8);
`endif
    tick(1);
    tick(32);
    check("t2_gnt_end", 32'(gnt), 32'b0001);
    req = 4'b0000;
    tick(1);

    // 3: owner 2 releases at cnt=3 with 3 waiting, then 3 releases alone
    req = 4'b1100;
    push(2, 0);
    push(3, 4);
    tick(1);
    tick(3);
    req = 4'b1000;
    tick(1);
    check("t3_gnt", 32'(gnt),     32'b1000);
    check("t3_cnt", 32'(dut.cnt), 32'd0);
    req = 4'b0000;
    tick(1);
    check("t3_idle_gnt",  32'(gnt),  32'd0);
    check("t3_idle_busy", 32'(busy), 32'd0);
    check("t3_hold_data", disp_data, 32'hA0A0_0003);
    tick(2);
    check("t3_hold_src",  32'(disp_src), 32'd3);

    // 4: lone requester keeps the display; data follows one cycle later
    req = 4'b0010;
    push(1, 0);
    tick(1);
    for (int i = 0; i < 30; i++) begin
      check("t4_hold_gnt", 32'(gnt), 32'b0010);
      tick(1);
    end
    data_in[63:32] = 32'h1234_5678;
    tick(1);
    check("t4_data_follow", disp_data, 32'h1234_5678);
    req = 4'b0000;
    tick(1);
    data_in[63:32] = 32'hA0A0_0001;

    // 5: requester 0 arrives while 2 owns at cnt=2 (3 also waiting)
    req = 4'b0100;
    push(2, 0);
`ifdef DISP_ARBITER_PRIO_EN
    push(0, 3);
`else
    push(3, 8);
    push(0, 8);
`endif
    tick(1);
    tick(2);
    req = 4'b1101;
    tick(1);
`ifdef DISP_ARBITER_PRIO_EN
    check("t5_preempt", 32'(gnt), 32'b0001);
`else
    check("t5_no_preempt", 32'(gnt), 32'b0100);
`endif
    tick(13);
    check("t5_gnt_late", 32'(gnt), 32'b0001);
    req = 4'b0000;
    tick(1);

    // 6: asynchronous reset mid-SHOW, then restart from requester 0
    req = 4'b1111;
`ifdef DISP_ARBITER_PRIO_EN
    push(0, 0);
`else
    push(1, 0);
`endif
    tick(1);
    tick(3);
    rst_n = 1'b0;
    #1;
    check("t6_rst_gnt",   32'(gnt),          32'd0);
    check("t6_rst_data",  disp_data,         32'd0);
    check("t6_rst_src",   32'(disp_src),     32'd0);
    check("t6_rst_pulse", 32'(switch_pulse), 32'd0);
    check("t6_rst_busy",  32'(busy),         32'd0);
    tick(1);
    rst_n = 1'b1;
    push(0, 0);
    tick(1);
    check("t6_first_gnt", 32'(gnt), 32'b0001);
    req = 4'b0000;
    tick(2);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/disp_arbiter.md
# disp_arbiter

Time-shares the board's single 8-digit seven-segment display between up to `N_REQ` requesters, for example PC, ALU result, register readback and memory probe. It grants the display round-robin, holding each grant for a minimum dwell time. It forwards the owner's 32-bit word, registered, to the display scanner's `data` input. It sits between the CPU debug taps and the display driver and is the only block that drives the scanner's data word.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `DWELL`, default 50_000_000: minimum cycles a grant is held when others are waiting; must be ≥ 2.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  N_REQ  requester i wants the display; level-sensitive.
- `data_in`  in  32*N_REQ  requester i's word at [32*i+31:32*i].
- `gnt`  out  N_REQ  one-hot grant, or all-zero when idle.
- `disp_data`  out  32  registered word to the scanner.
- `disp_src`  out  SW  index of current/last owner; SW = max(1, $clog2(N_REQ)).
- `switch_pulse`  out  1  one-cycle pulse whenever ownership is newly granted or changes.
- `busy`  out  1  equals |gnt.

## Operation
- The state machine has two states.
  - IDLE: `gnt`=0. `disp_data` and `disp_src` hold their last values.
  - SHOW: exactly one `gnt` bit is set. The dwell counter `cnt` has width $clog2(DWELL).
- Round-robin pick: search from `(last+1) mod N_REQ` upward with wrap, and take the first asserted `req` bit. `last` is the current or most recent owner. `last` resets to N_REQ-1, so requester 0 wins first.
- IDLE → SHOW: when any `req` is set, grant the picked requester, clear `cnt`, and pulse `switch_pulse`.
- In SHOW, every cycle: `disp_data` ← owner's `data_in` slice, and `cnt` increments, saturating at DWELL-1.
- SHOW, owner's `req` drops (release):
  - If any other `req` is set, the grant passes to the picked requester with `cnt` cleared and a `switch_pulse`.
  - Otherwise the block goes to IDLE.
- SHOW, `cnt` == DWELL-1 and another `req` is set: rotate to the picked requester, clear `cnt`, pulse `switch_pulse`.
- SHOW, `cnt` == DWELL-1 and no other `req` is set: ownership is kept with no pulse, and `cnt` stays saturated.
- Owner release in the same cycle as dwell expiry is handled as a release.
- A new grant never goes to a requester whose `req` is low.
- A requester that drops `req` while waiting is simply skipped.

## Timing
- Reset values: `gnt`=0, `disp_data`=0, `disp_src`=0, `switch_pulse`=0, `busy`=0, state IDLE, `cnt`=0, `last`=N_REQ-1.
- Reset is asserted asynchronously and released on the next `clk` edge after `rst_n` rises. Reset mid-SHOW returns every output to its reset value immediately.
- Grant latency: `req` sampled high at edge t gives `gnt`, `disp_src`, `busy`, `switch_pulse` and the first `disp_data` valid after edge t.
- Data latency: a `data_in` change of the owner appears on `disp_data` one cycle later.
- Release latency: `req` low sampled at edge t clears or moves `gnt` after edge t.
- Rotation period with all requesters active: DWELL cycles per owner.

## Configuration
- Macro: `DISP_ARBITER_PRIO_EN`.
- Defined: requester 0 has absolute priority.
  - `req[0]` high while another requester owns the display forces a switch to 0 on the next edge, regardless of `cnt`, with a `switch_pulse`.
  - While 0 owns and `req[0]` is high, the dwell expiry never rotates away.
  - After 0 releases, the round-robin pick starts from 1.
- Undefined: requester 0 is an ordinary round-robin participant.

## Structure
- Shared package `disp_pkg` holds:
  - the state enum (`DA_IDLE`, `DA_SHOW`);
  - `DISP_W`=32;
  - the `DISP_MAX_REQ`=8 constant.
- One combinational sub-module, `disp_rr_pick`, takes (`req`, `last`) and returns (`found`, `idx`) for the wrapped search. The FSM, counter and output registers stay in `disp_arbiter`.

## Test plan
All scenarios use N_REQ=4, DWELL=8, and `data_in[i]` = 32'hA0A0_0000+i.
1. Reset with `req`=0 → all outputs are zero. Setting `req`=4'b0010 at edge t → after t: `gnt`=0010, `disp_src`=1, `switch_pulse` for one cycle, `disp_data`=A0A0_0001.
2. `req`=4'b1111 held → owners are 0, 1, 2, 3, 0, each for exactly 8 cycles, with one `switch_pulse` per change.
3. Owner 2 drops `req` at `cnt`=3 while `req[3]`=1 → next cycle `gnt`=1000, `cnt`=0. Owner 3 dropping with no other requests → `gnt`=0 and `disp_data` holds A0A0_0003.
4. Only `req[1]` held for 30 cycles → `gnt`=0010 throughout, a single `switch_pulse`. Changing `data_in[1]` to 1234_5678 → `disp_data`=1234_5678 one cycle later.
5. With `DISP_ARBITER_PRIO_EN`: owner 2 at `cnt`=2, raise `req[0]` → `gnt`=0001 next cycle. Without the macro → `gnt`=0001 is not set until owner 2 has held for 8 cycles, after 3 is served.
6. `rst_n` low mid-SHOW → outputs are zero immediately. After release with `req`=1111 → first `gnt`=0001.
